// File: rtl/des32b_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des32b_pkg: shared state type, widths and default alignment pattern.
// Rev 1.0
// ----------------------------------------------------------------------------
package des32b_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } des32b_state_t;

  localparam int WORD_W   = 32;
  localparam int ERRCNT_W = 16;
  localparam int BITERR_W = 24;
  localparam int POPCNT_W = 6;

  localparam logic [WORD_W-1:0] DEF_PATTERN = 32'hA5C3_0F96;

  function automatic logic [POPCNT_W-1:0] popcount(input logic [WORD_W-1:0] v);
    logic [POPCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WORD_W; i++) begin
      n = n + POPCNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des32b_satcnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des32b_satcnt: saturating up-counter with variable increment and sync clear.
// Rev 1.0
// ----------------------------------------------------------------------------
module des32b_satcnt #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             CLKBit,
  input  logic             RSTn,
  input  logic             i_clr,
  input  logic             i_inc_en,
  input  logic [INC_W-1:0] i_inc,
  output logic [W-1:0]     o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W:0]   w_sum;

  // One extra bit catches the carry so overflow clamps to all-ones.
  assign w_sum = {1'b0, r_cnt} + (W+1)'(i_inc);

  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc_en) begin
      r_cnt <= w_sum[W] ? '1 : w_sum[W-1:0];
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/des32b_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des32b_align: serial word-boundary recovery, lock qualification and SEU error
// counting. Define DES32B_BITERR_EN to add the BitErrCnt bit-error counter.
// Rev 1.0
// ----------------------------------------------------------------------------
module des32b_align
  import des32b_pkg::*;
#(
  parameter logic [WORD_W-1:0] PATTERN    = DEF_PATTERN,
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_THR = 8
) (
  input  logic                CLKBit,
  input  logic                RSTn,
  input  logic                DataIn,
  input  logic                ErrClr,
  output logic                CLKWord,
  output logic [WORD_W-1:0]   DataOut,
  output logic                WordValid,
  output logic                Locked,
  output logic [ERRCNT_W-1:0] ErrCnt
`ifdef DES32B_BITERR_EN
  ,
  output logic [BITERR_W-1:0] BitErrCnt
`endif
);

  localparam logic [3:0] c_lock_cnt   = 4'(LOCK_CNT);
  localparam logic [3:0] c_unlock_thr = 4'(UNLOCK_THR);

  des32b_state_t     r_state;
  logic [WORD_W-1:0] r_sr;
  logic [WORD_W-1:0] r_data;
  logic [4:0]        r_phase;
  logic [3:0]        r_good_cnt;
  logic [3:0]        r_bad_run;
  logic              r_valid;
  logic              r_locked;

  logic w_match;
  logic w_word_done;
  logic w_err_inc;

  assign w_match     = (r_sr == PATTERN);
  // While searching, any pattern hit re-anchors the word boundary.
  assign w_word_done = (r_state == SEARCH) ? w_match : (r_phase == 5'd0);
  assign w_err_inc   = w_word_done && (r_state == LOCKED) && !w_match;

  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_sr    <= '0;
      r_phase <= 5'b11111;
      r_data  <= '0;
    end else begin
      r_sr    <= {r_sr[WORD_W-2:0], DataIn};
      r_phase <= w_word_done ? 5'd31 : (r_phase - 5'd1);
      if (w_word_done) begin
        r_data <= r_sr;
      end
    end
  end

  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= SEARCH;
      r_good_cnt <= '0;
      r_bad_run  <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_valid <= w_word_done && (r_state != SEARCH);
      if (w_word_done) begin
        unique case (r_state)
          SEARCH: begin
            r_good_cnt <= 4'd1;
            r_bad_run  <= '0;
            if (c_lock_cnt == 4'd1) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state <= CHECK;
            end
          end
          CHECK: begin
            if (w_match) begin
              r_good_cnt <= r_good_cnt + 4'd1;
              if ((r_good_cnt + 4'd1) == c_lock_cnt) begin
                r_state   <= LOCKED;
                r_locked  <= 1'b1;
                r_bad_run <= '0;
              end
            end else begin
              r_state    <= SEARCH;
              r_good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_bad_run <= '0;
            end else if ((r_bad_run + 4'd1) == c_unlock_thr) begin
              r_state    <= SEARCH;
              r_locked   <= 1'b0;
              r_bad_run  <= '0;
              r_good_cnt <= '0;
            end else begin
              r_bad_run <= r_bad_run + 4'd1;
            end
          end
          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  des32b_satcnt #(
    .W     (ERRCNT_W),
    .INC_W (1)
  ) u_errcnt (
    .CLKBit   (CLKBit),
    .RSTn     (RSTn),
    .i_clr    (ErrClr),
    .i_inc_en (w_err_inc),
    .i_inc    (1'b1),
    .o_cnt    (ErrCnt)
  );

`ifdef DES32B_BITERR_EN
  logic                w_bit_inc_en;
  logic [POPCNT_W-1:0] w_bit_inc;

  // A matching word adds zero, so every LOCKED boundary may increment.
  assign w_bit_inc_en = w_word_done && (r_state == LOCKED);
  assign w_bit_inc    = popcount(r_sr ^ PATTERN);

  des32b_satcnt #(
    .W     (BITERR_W),
    .INC_W (POPCNT_W)
  ) u_biterrcnt (
    .CLKBit   (CLKBit),
    .RSTn     (RSTn),
    .i_clr    (ErrClr),
    .i_inc_en (w_bit_inc_en),
    .i_inc    (w_bit_inc),
    .o_cnt    (BitErrCnt)
  );
`endif

  assign CLKWord   = r_phase[4];
  assign DataOut   = r_data;
  assign WordValid = r_valid;
  assign Locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_des32b_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_des32b_align: table vectors, corner sequences and random stream vs model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_des32b_align;

  localparam logic [31:0] PAT      = 32'hA5C3_0F96;
  localparam int          LOCK_N   = 4;
  localparam int          UNLOCK_N = 8;

  logic        CLKBit = 1'b0;
  logic        RSTn;
  logic        DataIn;
  logic        ErrClr;
  logic        CLKWord;
  logic        WordValid;
  logic        Locked;
  logic [31:0] DataOut;
  logic [15:0] ErrCnt;
`ifdef DES32B_BITERR_EN
  logic [23:0] BitErrCnt;
`endif

  logic        sc_clr;
  logic        sc_en;
  logic [15:0] sc_inc;
  logic [15:0] sc_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: bit history, bits since the last boundary, mode 0/1/2.
  logic [31:0] m_hist;
  logic [31:0] m_data;
  logic        m_valid;
  int          m_cnt;
  int          m_mode;
  int          m_good;
  int          m_bad;
  int unsigned m_err;
  int unsigned m_biterr;

  typedef struct {
    int          pre;
    int          g1;
    logic [31:0] bad;
    int          nbad;
    int          g2;
    logic        exp_locked;
    logic [15:0] exp_err;
    logic [23:0] exp_bits;
  } row_t;

  row_t rows[9];

  always #5 CLKBit = ~CLKBit;

  des32b_align dut (
    .CLKBit    (CLKBit),
    .RSTn      (RSTn),
    .DataIn    (DataIn),
    .ErrClr    (ErrClr),
    .CLKWord   (CLKWord),
    .DataOut   (DataOut),
    .WordValid (WordValid),
    .Locked    (Locked),
    .ErrCnt    (ErrCnt)
`ifdef DES32B_BITERR_EN
    ,
    .BitErrCnt (BitErrCnt)
`endif
  );

  des32b_satcnt #(.W(16), .INC_W(16)) u_sc (
    .CLKBit   (CLKBit),
    .RSTn     (RSTn),
    .i_clr    (sc_clr),
    .i_inc_en (sc_en),
    .i_inc    (sc_inc),
    .o_cnt    (sc_cnt)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] dut_biterr();
`ifdef DES32B_BITERR_EN
    return BitErrCnt;
`else
    return 24'h0;
`endif
  endfunction

  function automatic logic [95:0] dut_vec();
    return {21'h0, CLKWord, WordValid, Locked, DataOut, ErrCnt, dut_biterr()};
  endfunction

  function automatic logic [95:0] model_vec();
    logic        cw;
    logic        lk;
    logic [23:0] bits;
    cw = ((m_cnt % 32) < 16);
    lk = (m_mode == 2);
`ifdef DES32B_BITERR_EN
    bits = 24'(m_biterr);
`else
    bits = 24'h0;
`endif
    return {21'h0, cw, m_valid, lk, m_data, 16'(m_err), bits};
  endfunction

  task automatic model_reset();
    m_hist = '0; m_data = '0; m_valid = 1'b0;
    m_cnt = 0; m_mode = 0; m_good = 0; m_bad = 0;
    m_err = 0; m_biterr = 0;
  endtask

  task automatic model_edge(input logic b, input logic clr);
    logic match;
    logic done;
    match = (m_hist == PAT);
    done  = (m_mode == 0) ? match : ((m_cnt % 32) == 31);
    m_valid = done && (m_mode != 0);
    if (clr) begin
      m_err = 0;
      m_biterr = 0;
    end else if (done && m_mode == 2) begin
      if (!match && m_err < 32'd65535) m_err++;
      m_biterr = m_biterr + $countones(m_hist ^ PAT);
      if (m_biterr > 32'h00FF_FFFF) m_biterr = 32'h00FF_FFFF;
    end
    if (done) begin
      m_data = m_hist;
      case (m_mode)
        0: begin
          m_good = 1;
          m_mode = (LOCK_N == 1) ? 2 : 1;
        end
        1: begin
          if (match) begin
            m_good++;
            if (m_good == LOCK_N) m_mode = 2;
          end else begin
            m_mode = 0;
            m_good = 0;
          end
        end
        default: begin
          if (match) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == UNLOCK_N) begin
              m_mode = 0;
              m_bad = 0;
            end
          end
        end
      endcase
    end
    m_cnt  = done ? 0 : m_cnt + 1;
    m_hist = {m_hist[30:0], b};
  endtask

  task automatic step(input logic b, input logic clr);
    DataIn = b;
    ErrClr = clr;
    @(posedge CLKBit);
    model_edge(b, clr);
    @(negedge CLKBit);
    chk("cycle", dut_vec(), model_vec());
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) step(w[i], 1'b0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0; DataIn = 1'b0; ErrClr = 1'b0;
    model_reset();
    @(posedge CLKBit);
    @(negedge CLKBit);
    chk("reset", dut_vec(), {21'h0, 1'b1, 2'b00, 72'h0});
    RSTn = 1'b1;
  endtask

  task automatic sc_tick();
    @(posedge CLKBit);
    @(negedge CLKBit);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pw;
    int          pulses;
    int          r;
    sc_clr = 1'b0; sc_en = 1'b0; sc_inc = '0;
    RSTn = 1'b0; DataIn = 1'b0; ErrClr = 1'b0;
    pw = PAT;

    rows[0] = '{7,  4, 32'h0,         0, 0, 1'b1, 16'd0, 24'd0};
    rows[1] = '{7,  3, 32'h0,         0, 0, 1'b0, 16'd0, 24'd0};
    rows[2] = '{3,  6, 32'hA5C3_0F97, 1, 2, 1'b1, 16'd1, 24'd1};
    rows[3] = '{11, 6, 32'h0,         8, 0, 1'b0, 16'd8, 24'd128};
    rows[4] = '{5,  6, 32'h0,         8, 4, 1'b1, 16'd8, 24'd128};
    rows[5] = '{5,  6, 32'h0,         7, 1, 1'b1, 16'd7, 24'd112};
    rows[6] = '{9,  2, 32'h0,         1, 3, 1'b0, 16'd0, 24'd0};
    rows[7] = '{9,  2, 32'h0,         1, 4, 1'b1, 16'd0, 24'd0};
    rows[8] = '{0,  5, 32'hFFFF_FFFF, 3, 0, 1'b1, 16'd3, 24'd48};

    for (int k = 0; k < 9; k++) begin
      do_reset();
      repeat (rows[k].pre) step(1'b0, 1'b0);
      repeat (rows[k].g1) send_word(PAT);
      repeat (rows[k].nbad) send_word(rows[k].bad);
      repeat (rows[k].g2) send_word(PAT);
      repeat (2) step(1'b0, 1'b0);
      chk($sformatf("row%0d_locked", k), 96'(Locked), 96'(rows[k].exp_locked));
      chk($sformatf("row%0d_errcnt", k), 96'(ErrCnt), 96'(rows[k].exp_err));
`ifdef DES32B_BITERR_EN
      chk($sformatf("row%0d_biterr", k), 96'(BitErrCnt), 96'(rows[k].exp_bits));
`endif
    end

    // Lock edge timing and WordValid cadence.
    do_reset();
    repeat (7) step(1'b0, 1'b0);
    repeat (4) send_word(PAT);
    chk("lock_early", 96'(Locked), 96'(1'b0));
    pulses = 0;
    for (int k = 0; k < 64; k++) begin
      step(pw[31 - (k % 32)], 1'b0);
      if (k == 0) chk("lock_edge", 96'({Locked, WordValid, DataOut}), 96'({2'b11, PAT}));
      if (WordValid) pulses++;
    end
    chk("valid_pulses", 96'(pulses), 96'(2));

    // ErrClr coinciding with an error increment.
    send_word(32'h0);
    step(1'b0, 1'b0);
    chk("err_one", 96'({Locked, ErrCnt}), 96'({1'b1, 16'd1}));
    repeat (31) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("clr_wins", 96'({Locked, ErrCnt}), 96'({1'b1, 16'd0}));

    // Asynchronous reset mid-word while locked.
    for (int k = 0; k < 13; k++) step(pw[31 - k], 1'b0);
    #2;
    RSTn = 1'b0;
    #1;
    chk("async_reset", dut_vec(), {21'h0, 1'b1, 2'b00, 72'h0});
    model_reset();
    @(negedge CLKBit);
    DataIn = 1'b0;
    RSTn = 1'b1;
    repeat (4) send_word(PAT);
    chk("relock_pending", 96'(Locked), 96'(1'b0));
    step(1'b0, 1'b0);
    chk("relock", 96'(Locked), 96'(1'b1));

    // Saturation of the counter building block.
    sc_en = 1'b1; sc_inc = 16'hFFF0;
    sc_tick();
    chk("sat_load", 96'(sc_cnt), 96'(16'hFFF0));
    sc_inc = 16'h0001;
    repeat (5) sc_tick();
    chk("sat_mid", 96'(sc_cnt), 96'(16'hFFF5));
    repeat (15) sc_tick();
    chk("sat_hold", 96'(sc_cnt), 96'(16'hFFFF));
    sc_inc = 16'h8000;
    sc_tick();
    chk("sat_bigadd", 96'(sc_cnt), 96'(16'hFFFF));
    sc_clr = 1'b1;
    sc_tick();
    chk("sat_clr_wins", 96'(sc_cnt), 96'(16'h0000));
    sc_clr = 1'b0; sc_en = 1'b0; sc_inc = '0;

    // Random word stream with slips, corruption and sporadic ErrClr.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 92) begin
        if (r < 65)      pw = PAT;
        else if (r < 75) pw = PAT ^ (32'h1 << $urandom_range(0, 31));
        else if (r < 85) pw = 32'h0;
        else             pw = $urandom;
        for (int i = 31; i >= 0; i--) step(pw[i], ($urandom_range(0, 199) == 0));
      end else begin
        repeat ($urandom_range(1, 5)) step(1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des32b_align.md
# des32b_align

Serial-to-parallel receiver for the 32-bit MSB-first stream produced by the team's 32:1 serializer in the SEU/SEE test chain. It recovers the word boundary by searching the serial stream for a fixed 32-bit pattern, then qualifies lock and counts mismatched words for SEU error accounting. It sits at the bit-rate input of the test receiver, driven by the same bit clock as the serial data.

## Interface
- PATTERN, 32'hA5C3_0F96: expected transmitted word; used for alignment and error checking.
- LOCK_CNT, 4: number of consecutive matching words needed to enter LOCKED (range 1–15).
- UNLOCK_THR, 8: number of consecutive mismatching words in LOCKED that force a return to SEARCH (range 1–15).
- CLKBit  input  1  bit clock; all logic on posedge.
- RSTn  input  1  reset, asynchronous, active-low.
- DataIn  input  1  serial data, MSB of each word first, sampled on posedge CLKBit.
- ErrClr  input  1  synchronous clear of ErrCnt (and BitErrCnt).
- CLKWord  output  1  word clock, equal to phase[4].
- DataOut  output  32  last complete aligned word.
- WordValid  output  1  one-CLKBit pulse when DataOut updates.
- Locked  output  1  high in state LOCKED.
- ErrCnt  output  16  mismatched words seen in LOCKED; saturates at 16'hFFFF.

## Operation
- Shift register: sr <= {sr[30:0], DataIn} every cycle.
- Phase counter, 5 bits: decrements every cycle and wraps 0→31.
- word_done:
  - In SEARCH: (sr == PATTERN).
  - In CHECK/LOCKED: (phase == 0).
- On word_done: phase <= 31, DataOut <= sr.
- WordValid = registered word_done in CHECK/LOCKED; it never pulses in SEARCH.
- FSM states: SEARCH, CHECK, LOCKED.
  - SEARCH, word_done: go to CHECK with good_cnt = 1.
  - CHECK, word_done with match: good_cnt + 1. If this reaches LOCK_CNT, go to LOCKED. LOCK_CNT = 1 means SEARCH goes directly to LOCKED.
  - CHECK, word_done with mismatch: go to SEARCH, good_cnt = 0.
  - LOCKED, word_done with match: bad_run = 0.
  - LOCKED, word_done with mismatch: ErrCnt + 1 (saturating) and bad_run + 1. When bad_run reaches UNLOCK_THR, go to SEARCH and clear bad_run.
- Match means sr == PATTERN, compared against the full 32 bits.
- If ErrClr and an error increment occur in the same cycle, ErrClr wins and the counter becomes 0.
- Realignment in SEARCH is immediate on any pattern hit, including a hit inside what would have been a word.

## Timing
- Reset values:
  - sr = 0, phase = 5'b11111 (so CLKWord = 1), DataOut = 0.
  - WordValid = 0, Locked = 0, ErrCnt = 0, state = SEARCH.
- Latency: the last bit of a word is on DataIn at edge N, lands in sr at N, and appears on DataOut at N+1. WordValid is high during the cycle after N+1.
- CLKWord has a 50 % duty cycle with period 32 CLKBit. It rises on the same edge that updates DataOut, so downstream logic samples DataOut on the CLKWord falling edge or with WordValid.
- In SEARCH, CLKWord free-runs and may glitch-stretch at a realignment. No clean-clock guarantee applies before Locked.
- Locked rises on the edge of the LOCK_CNT-th matching word_done and falls on the UNLOCK_THR-th consecutive mismatch edge.
- RSTn asserted mid-word: all state returns to reset values immediately. After release, a full SEARCH is required.

## Configuration
- DES32B_BITERR_EN:
  - Defined: adds output BitErrCnt [23:0], reset 0. In LOCKED, each word_done adds popcount(sr ^ PATTERN), saturating at 24'hFFFFFF. ErrClr clears it.
  - Undefined: the port and logic are absent; only word-level ErrCnt exists.

## Structure
- Package des32b_pkg holds:
  - The state enum (SEARCH/CHECK/LOCKED).
  - Constants WORD_W = 32, ERRCNT_W = 16, BITERR_W = 24, and the default PATTERN.
- One sub-module, des32b_satcnt: a parameterized width/increment saturating counter with synchronous clear, instantiated for ErrCnt and, when enabled, for BitErrCnt.

## Test plan
- Reset, then feed PATTERN continuously at an arbitrary bit offset (e.g. 7) → Locked = 1 exactly at the 4th matched word_done; DataOut = 32'hA5C3_0F96; WordValid pulses every 32 cycles.
- Locked, then flip 1 bit in one word → ErrCnt = 1, Locked stays 1; with DES32B_BITERR_EN, BitErrCnt = 1.
- Locked, then send 8 consecutive words of 32'h0 → ErrCnt = 8, Locked = 0 after the 8th word; relock 4 words after PATTERN resumes.
- CHECK state (2 good words), then 1 bad word → back to SEARCH, Locked never asserts until 4 new consecutive matches.
- ErrCnt preloaded near saturation (65 540 bad words without unlock, UNLOCK_THR = 15 with interleaved good words) → ErrCnt holds at 16'hFFFF; ErrClr pulse → 0.
- Pulse RSTn low mid-word while Locked → all outputs return to reset values next cycle; CLKWord = 1; relock required.
